membank_swap: RTL and testbench

Clocked N-bank frame-buffer swap controller that generalises the two-bank master/viewer memory mux. One writer port (M) fills a back bank while a viewer port (V) scans out the front bank. Bank ownership changes only at clock edges, on a writer "frame done" pulse and a viewer frame-boundary pulse. Double buffering (BANKS=2) or triple/quad buffering (BANKS=3..4) is selected by parameter, and frames are dropped when the writer outruns the viewer.

---
 rtl/membank_swap_if.sv | 29 ++
 rtl/membank_swap.sv | 98 +++++++++
 tb/tb_membank_swap.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/membank_swap_if.sv
// Writer/viewer side of the N-bank frame-buffer swap controller.
// The controller owns the slave modport; the writer/viewer client owns master.
interface membank_swap_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_we;
   logic                  m_done;
   logic                  m_ready;
   logic [ADDR_WIDTH-1:0] v_addr;
   logic [DATA_WIDTH-1:0] v_data;
   logic                  v_sync;
   logic                  v_swap;
   logic [1:0]            rd_bank;
   logic [1:0]            wr_bank;
   logic [7:0]            drop_cnt;

   modport master (
      output m_addr, m_data, m_we, m_done, v_addr, v_sync,
      input  m_ready, v_data, v_swap, rd_bank, wr_bank, drop_cnt
   );

   modport slave (
      input  m_addr, m_data, m_we, m_done, v_addr, v_sync,
      output m_ready, v_data, v_swap, rd_bank, wr_bank, drop_cnt
   );
endinterface

// File: rtl/membank_swap.sv
// N-bank (2..4) frame-buffer swap controller: writer fills a back bank while the
// viewer scans the front bank; ownership rotates on m_done / v_sync pulses.
module membank_swap #(
   parameter int BANKS      = 3,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   membank_swap_if.slave               bus,
   output logic [BANKS*ADDR_WIDTH-1:0] s_addr,
   inout  wire  [BANKS*DATA_WIDTH-1:0] s_data,
   output logic [BANKS-1:0]            s_we
);
   logic [1:0]            rd_q, wr_q, pend_q;
   logic                  pend_v_q, ready_q, swap_q;
   logic [7:0]            drop_q;
   logic [DATA_WIDTH-1:0] vdata_q;

   logic [1:0]            rd_n, wr_n, pend_n, free;
   logic                  pend_v_n, ready_n, swap_n;
   logic [7:0]            drop_n;

   always_comb begin
      rd_n     = rd_q;
      wr_n     = wr_q;
      pend_n   = pend_q;
      pend_v_n = pend_v_q;
      ready_n  = ready_q;
      drop_n   = drop_q;
      swap_n   = 1'b0;
      free     = 2'd0;

      // swap sees pre-edge pending state; m_done below sees the post-swap view
      if (bus.v_sync && pend_v_q) begin
         rd_n     = pend_q;
         pend_v_n = 1'b0;
         swap_n   = 1'b1;
         if (BANKS == 2) begin
            wr_n    = rd_q;
            ready_n = 1'b1;
         end
      end

      for (int i = BANKS - 1; i >= 0; i--)
         if (2'(i) != rd_n && 2'(i) != wr_q) free = 2'(i);

      if (bus.m_done && ready_q) begin
         if (BANKS == 2) begin
            ready_n = 1'b0;
         end else if (pend_v_n) begin
            // writer outran the viewer: recycle the older pending frame
            wr_n = pend_q;
            if (drop_q != 8'hFF) drop_n = drop_q + 8'd1;
         end else begin
            wr_n = free;
         end
         pend_n   = wr_q;
         pend_v_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q     <= 2'd0;
         wr_q     <= 2'd1;
         pend_q   <= 2'd0;
         pend_v_q <= 1'b0;
         ready_q  <= 1'b1;
         drop_q   <= 8'd0;
         swap_q   <= 1'b0;
         vdata_q  <= '0;
      end else begin
         rd_q     <= rd_n;
         wr_q     <= wr_n;
         pend_q   <= pend_n;
         pend_v_q <= pend_v_n;
         ready_q  <= ready_n;
         drop_q   <= drop_n;
         swap_q   <= swap_n;
         vdata_q  <= s_data[rd_q*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   for (genvar i = 0; i < BANKS; i++) begin : g_bank
      localparam logic [1:0] IDX = 2'(i);
      assign s_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = (wr_q == IDX) ? bus.m_addr : bus.v_addr;
      assign s_we[i]                            = (wr_q == IDX) & bus.m_we & ready_q;
      assign s_data[i*DATA_WIDTH +: DATA_WIDTH] = s_we[i] ? bus.m_data : {DATA_WIDTH{1'bz}};
   end

   assign bus.rd_bank  = rd_q;
   assign bus.wr_bank  = wr_q;
   assign bus.m_ready  = ready_q;
   assign bus.drop_cnt = drop_q;
   assign bus.v_swap   = swap_q;
   assign bus.v_data   = vdata_q;
endmodule

// File: tb/tb_membank_swap.sv
// Scoreboard bench for membank_swap: a triple-buffered and a double-buffered
// instance, each with a behavioural bank memory on its s_* bus.
module tb_membank_swap;
   logic clk = 1'b0;
   logic rst_n;
   logic mem_init;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   membank_swap_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if3 ();
   membank_swap_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if2 ();

   logic [23:0] s_addr3;
   wire  [23:0] s_data3;
   logic [2:0]  s_we3;
   logic [15:0] s_addr2;
   wire  [15:0] s_data2;
   logic [1:0]  s_we2;

   membank_swap #(.BANKS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) u3 (
      .clk(clk), .rst_n(rst_n), .bus(if3),
      .s_addr(s_addr3), .s_data(s_data3), .s_we(s_we3));
   membank_swap #(.BANKS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(if2),
      .s_addr(s_addr2), .s_data(s_data2), .s_we(s_we2));

   // bank memories; initial content of bank b at address a is b*64+a
   for (genvar b = 0; b < 3; b++) begin : g_m3
      logic [7:0] m [256];
      assign s_data3[b*8 +: 8] = s_we3[b] ? 8'bz : m[s_addr3[b*8 +: 8]];
      always @(posedge clk)
         if (mem_init) for (int a = 0; a < 256; a++) m[a] <= 8'(b*64 + a);
         else if (s_we3[b]) m[s_addr3[b*8 +: 8]] <= s_data3[b*8 +: 8];
   end
   for (genvar b = 0; b < 2; b++) begin : g_m2
      logic [7:0] m [256];
      assign s_data2[b*8 +: 8] = s_we2[b] ? 8'bz : m[s_addr2[b*8 +: 8]];
      always @(posedge clk)
         if (mem_init) for (int a = 0; a < 256; a++) m[a] <= 8'(b*64 + a);
         else if (s_we2[b]) m[s_addr2[b*8 +: 8]] <= s_data2[b*8 +: 8];
   end

   localparam int F_RD3 = 0, F_WR3 = 1, F_RDY3 = 2, F_SWP3 = 3, F_DROP3 = 4,
                  F_VD3 = 5, F_WE3 = 6, F_MEM3 = 7, F_RD2 = 8, F_WR2 = 9,
                  F_RDY2 = 10, F_SWP2 = 11, F_WE2 = 12, F_MEM2 = 13;

   typedef struct {
      int          tgt;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] actual(int sel);
      case (sel)
         F_RD3:   return 32'(if3.rd_bank);
         F_WR3:   return 32'(if3.wr_bank);
         F_RDY3:  return 32'(if3.m_ready);
         F_SWP3:  return 32'(if3.v_swap);
         F_DROP3: return 32'(if3.drop_cnt);
         F_VD3:   return 32'(if3.v_data);
         F_WE3:   return 32'(s_we3);
         F_MEM3:  return 32'(g_m3[1].m[3]);
         F_RD2:   return 32'(if2.rd_bank);
         F_WR2:   return 32'(if2.wr_bank);
         F_RDY2:  return 32'(if2.m_ready);
         F_SWP2:  return 32'(if2.v_swap);
         F_WE2:   return 32'(s_we2);
         F_MEM2:  return 32'(g_m2[1].m[5]);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // queue an expectation to be checked on the falling edge 'dly' cycles ahead
   task automatic expect_at(input string name, input int sel, input logic [31:0] e, input int dly);
      exp_t x;
      int   k;
      x.tgt = cyc + dly; x.sel = sel; x.exp = e; x.name = name;
      k = sb.size();
      while (k > 0 && sb[k-1].tgt > x.tgt) k--;
      sb.insert(k, x);
   endtask

   always @(negedge clk) begin
      exp_t        x;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
         x   = sb.pop_front();
         act = actual(x.sel);
         checks++;
         if (x.tgt != cyc) begin
            fails++;
            $display("FAIL %s: not sampled in cycle %0d (now %0d)", x.name, x.tgt, cyc);
         end else if (act !== x.exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", x.name, act, x.exp, cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse3(input logic d, input logic s);
      if3.m_done = d; if3.v_sync = s;
      step(1);
      if3.m_done = 1'b0; if3.v_sync = 1'b0;
   endtask

   task automatic pulse2(input logic d, input logic s);
      if2.m_done = d; if2.v_sync = s;
      step(1);
      if2.m_done = 1'b0; if2.v_sync = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_init = 1'b1;
      if3.m_addr = '0; if3.m_data = '0; if3.m_we = 1'b0; if3.m_done = 1'b0;
      if3.v_addr = '0; if3.v_sync = 1'b0;
      if2.m_addr = '0; if2.m_data = '0; if2.m_we = 1'b0; if2.m_done = 1'b0;
      if2.v_addr = '0; if2.v_sync = 1'b0;
      step(2);
      expect_at("rst_rd3",   F_RD3,   0, 0);
      expect_at("rst_wr3",   F_WR3,   1, 0);
      expect_at("rst_rdy3",  F_RDY3,  1, 0);
      expect_at("rst_drop3", F_DROP3, 0, 0);
      expect_at("rst_vd3",   F_VD3,   0, 0);
      expect_at("rst_swp3",  F_SWP3,  0, 0);
      expect_at("rst_rd2",   F_RD2,   0, 0);
      expect_at("rst_wr2",   F_WR2,   1, 0);
      step(1);
      rst_n = 1'b1; mem_init = 1'b0;
      step(1);

      // triple buffer: write to back bank 1, read front bank 0
      if3.m_addr = 8'd3; if3.m_data = 8'hA5; if3.m_we = 1'b1; if3.v_addr = 8'd3;
      expect_at("wr_s_we3", F_WE3, 3'b010, 0);
      step(1);
      if3.m_we = 1'b0;
      expect_at("wr_bank1_mem", F_MEM3, 8'hA5, 0);
      expect_at("rd_bank0_vd",  F_VD3,  8'h03, 0);

      pulse3(1'b1, 1'b0);
      expect_at("done_wr3", F_WR3, 2, 0);
      expect_at("done_rd3", F_RD3, 0, 0);
      step(1);
      pulse3(1'b0, 1'b1);
      expect_at("swap_rd3",     F_RD3,  1, 0);
      expect_at("swap_wr3",     F_WR3,  2, 0);
      expect_at("swap_pulse",   F_SWP3, 1, 0);
      expect_at("swap_pulse_end", F_SWP3, 0, 1);
      expect_at("swap_vd3",     F_VD3,  8'hA5, 1);
      step(2);

      // double buffer: writer stalls between m_done and the viewer swap
      if2.m_addr = 8'd5; if2.m_data = 8'h5A; if2.m_we = 1'b1;
      expect_at("b2_s_we", F_WE2, 2'b10, 0);
      step(1);
      if2.m_we = 1'b0;
      expect_at("b2_mem", F_MEM2, 8'h5A, 0);
      pulse2(1'b1, 1'b0);
      expect_at("b2_done_rdy", F_RDY2, 0, 0);
      expect_at("b2_done_wr",  F_WR2,  1, 0);
      if2.m_data = 8'h77; if2.m_we = 1'b1;
      expect_at("b2_gated_we", F_WE2, 2'b00, 0);
      step(1);
      if2.m_we = 1'b0;
      expect_at("b2_gated_mem", F_MEM2, 8'h5A, 0);
      pulse2(1'b0, 1'b1);
      expect_at("b2_swap_rd",  F_RD2,  1, 0);
      expect_at("b2_swap_wr",  F_WR2,  0, 0);
      expect_at("b2_swap_rdy", F_RDY2, 1, 0);
      expect_at("b2_swap_pls", F_SWP2, 1, 0);
      step(1);
      pulse2(1'b1, 1'b1);
      expect_at("b2_both_rdy", F_RDY2, 0, 0);
      expect_at("b2_both_rd",  F_RD2,  1, 0);
      expect_at("b2_both_swp", F_SWP2, 0, 0);
      step(1);
      pulse2(1'b0, 1'b1);
      expect_at("b2_next_rd",  F_RD2,  0, 0);
      expect_at("b2_next_wr",  F_WR2,  1, 0);
      expect_at("b2_next_rdy", F_RDY2, 1, 0);
      step(1);

      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
      expect_at("rst2_rd3", F_RD3, 0, 0);
      expect_at("rst2_wr3", F_WR3, 1, 0);

      // writer overrun: three frames with no viewer boundary
      for (int i = 0; i < 3; i++) begin
         pulse3(1'b1, 1'b0);
         step(1);
      end
      expect_at("ovr_drop", F_DROP3, 2, 0);
      expect_at("ovr_rd",   F_RD3,   0, 0);
      expect_at("ovr_wr",   F_WR3,   2, 0);
      pulse3(1'b1, 1'b0);
      expect_at("ovr4_drop", F_DROP3, 3, 0);
      expect_at("ovr4_wr",   F_WR3,   1, 0);
      step(1);

      // simultaneous with rd=0 wr=1 pend=2
      pulse3(1'b1, 1'b1);
      expect_at("sim_rd",   F_RD3,   2, 0);
      expect_at("sim_wr",   F_WR3,   0, 0);
      expect_at("sim_drop", F_DROP3, 3, 0);
      expect_at("sim_swp",  F_SWP3,  1, 0);
      step(1);
      pulse3(1'b0, 1'b1);
      expect_at("sim_pend_rd", F_RD3, 1, 0);
      expect_at("sim_pend_wr", F_WR3, 0, 0);
      step(1);

      // saturation: first pulse fills an empty pending slot, the rest drop
      for (int i = 0; i < 300; i++) begin
         pulse3(1'b1, 1'b0);
         if (i == 99) expect_at("sat_mid", F_DROP3, 102, 0);
         step(1);
      end
      expect_at("sat_drop", F_DROP3, 255, 0);
      expect_at("sat_rd",   F_RD3,   1, 0);
      step(1);

      // asynchronous reset with a pending frame outstanding
      rst_n = 1'b0;
      expect_at("arst_rd",   F_RD3,   0, 0);
      expect_at("arst_wr",   F_WR3,   1, 0);
      expect_at("arst_rdy",  F_RDY3,  1, 0);
      expect_at("arst_drop", F_DROP3, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      pulse3(1'b0, 1'b1);
      expect_at("arst_nosw_rd",  F_RD3,  0, 0);
      expect_at("arst_nosw_swp", F_SWP3, 0, 0);
      step(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
